// File: rtl/event_irq_ctrl.sv
// Event latch and IRQ/NMI mask block behind the event generator core, with PAR register access.
// Optional NMI mask and line are built when EVENT_IRQ_CTRL_NMI_EN is defined.
module event_irq_ctrl #(
  parameter int NUM_EVENTS      = 8,
  parameter int PAR_AW          = 12,
  parameter int PAR_DW          = 32,
  parameter int PAR_WW          = 4,
  parameter int EVENT_BASE      = 'h100,
  parameter int IRQ_ENABLE_ADDR = 'h300,
  parameter int IRQ_SET_ADDR    = 'h304,
  parameter int IRQ_CLR_ADDR    = 'h308,
  parameter int NMI_ENABLE_ADDR = 'h320,
  parameter int NMI_SET_ADDR    = 'h324,
  parameter int NMI_CLR_ADDR    = 'h328
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] eventPulse,
  input  logic [PAR_AW-1:0]     parAddr,
  input  logic                  parWrEn,
  input  logic [PAR_DW-1:0]     parWData,
  input  logic [PAR_WW-1:0]     parWStrb,
  input  logic                  parRdEn,
  output logic [PAR_DW-1:0]     parRData,
  output logic                  parRValid,
  output logic                  irq,
  output logic                  nmi,
  output logic [NUM_EVENTS-1:0] eventState
);

  localparam int EW = NUM_EVENTS;

  function automatic logic [PAR_AW-1:0] eventAddr(input int idx);
    return PAR_AW'(EVENT_BASE + idx * 32'sd4);
  endfunction

  // Plain-load / set / clear update of an enable mask, restricted to strobed lanes.
  function automatic logic [EW-1:0] maskWrite(input logic [EW-1:0] cur, input logic ld,
                                              input logic st, input logic cl,
                                              input logic [EW-1:0] d, input logic [EW-1:0] m);
    if (ld) begin
      return (cur & ~m) | (d & m);
    end else if (st) begin
      return cur | (d & m);
    end else if (cl) begin
      return cur & ~(d & m);
    end else begin
      return cur;
    end
  endfunction

  logic [EW-1:0]     events_r;
  logic [EW-1:0]     irqEn_r;
  logic              irq_r;
  logic [PAR_DW-1:0] parRData_r;
  logic              parRValid_r;

  logic [EW-1:0]     eventsNext_s;
  logic [EW-1:0]     irqEnNext_s;
  logic [EW-1:0]     evHit_s;
  logic [EW-1:0]     evMask_s;
  logic [EW-1:0]     wData_s;
  logic [PAR_DW-1:0] rdData_s;
  logic              unusedBits_s;

  assign wData_s = parWData[EW-1:0];

  // Address decode of EVENTS registers and byte-lane mask for enable bits.
  always_comb begin
    evHit_s  = {EW{1'b0}};
    evMask_s = {EW{1'b0}};
    for (int i = 0; i < EW; i++) begin
      evHit_s[i]  = (parAddr == eventAddr(i));
      evMask_s[i] = parWStrb[i / 8];
    end
  end

  // Sticky event bits: software write first, then a hardware pulse overrides a clear.
  always_comb begin
    eventsNext_s = events_r;
    for (int i = 0; i < EW; i++) begin
      if (parWrEn && parWStrb[0] && evHit_s[i]) begin
        eventsNext_s[i] = parWData[0] | eventPulse[i];
      end else begin
        eventsNext_s[i] = events_r[i] | eventPulse[i];
      end
    end
  end

  // IRQ enable mask next state.
  always_comb begin
    irqEnNext_s = maskWrite(irqEn_r,
                            parWrEn && (parAddr == PAR_AW'(IRQ_ENABLE_ADDR)),
                            parWrEn && (parAddr == PAR_AW'(IRQ_SET_ADDR)),
                            parWrEn && (parAddr == PAR_AW'(IRQ_CLR_ADDR)),
                            wData_s, evMask_s);
  end

`ifdef EVENT_IRQ_CTRL_NMI_EN
  logic [EW-1:0] nmiEn_r;
  logic [EW-1:0] nmiEnNext_s;
  logic          nmi_r;

  // NMI enable mask next state.
  always_comb begin
    nmiEnNext_s = maskWrite(nmiEn_r,
                            parWrEn && (parAddr == PAR_AW'(NMI_ENABLE_ADDR)),
                            parWrEn && (parAddr == PAR_AW'(NMI_SET_ADDR)),
                            parWrEn && (parAddr == PAR_AW'(NMI_CLR_ADDR)),
                            wData_s, evMask_s);
  end

  // NMI mask and registered NMI line.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmiEn_r <= {EW{1'b0}};
      nmi_r   <= 1'b0;
    end else begin
      nmiEn_r <= nmiEnNext_s;
      nmi_r   <= |(eventsNext_s & nmiEnNext_s);
    end
  end

  assign nmi          = nmi_r;
  assign unusedBits_s = ^{parWData, parWStrb};
`else
  assign nmi          = 1'b0;
  assign unusedBits_s = ^{parWData, parWStrb, PAR_AW'(NMI_ENABLE_ADDR),
                          PAR_AW'(NMI_SET_ADDR), PAR_AW'(NMI_CLR_ADDR)};
`endif

  // Read mux, sampled from current register state (read-before-write).
  always_comb begin
    rdData_s = {PAR_DW{1'b0}};
    case (parAddr)
      PAR_AW'(IRQ_ENABLE_ADDR),
      PAR_AW'(IRQ_SET_ADDR),
      PAR_AW'(IRQ_CLR_ADDR): rdData_s = PAR_DW'(irqEn_r);
`ifdef EVENT_IRQ_CTRL_NMI_EN
      PAR_AW'(NMI_ENABLE_ADDR),
      PAR_AW'(NMI_SET_ADDR),
      PAR_AW'(NMI_CLR_ADDR): rdData_s = PAR_DW'(nmiEn_r);
`endif
      default:               rdData_s = PAR_DW'(|(evHit_s & events_r));
    endcase
  end

  // Event, IRQ mask, IRQ line and read response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      events_r    <= {EW{1'b0}};
      irqEn_r     <= {EW{1'b0}};
      irq_r       <= 1'b0;
      parRData_r  <= {PAR_DW{1'b0}};
      parRValid_r <= 1'b0;
    end else begin
      events_r    <= eventsNext_s;
      irqEn_r     <= irqEnNext_s;
      irq_r       <= |(eventsNext_s & irqEnNext_s);
      parRData_r  <= parRdEn ? rdData_s : {PAR_DW{1'b0}};
      parRValid_r <= parRdEn;
    end
  end

  assign parRData   = parRData_r;
  assign parRValid  = parRValid_r;
  assign irq        = irq_r;
  assign eventState = events_r;

endmodule

// File: tb/tb_event_irq_ctrl.sv
// Directed + randomized bench for event_irq_ctrl against a per-cycle behavioural model.
module tb_event_irq_ctrl;

  localparam int NE = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] eventPulse;
  logic [11:0]   parAddr;
  logic          parWrEn;
  logic [31:0]   parWData;
  logic [3:0]    parWStrb;
  logic          parRdEn;
  logic [31:0]   parRData;
  logic          parRValid;
  logic          irq;
  logic          nmi;
  logic [NE-1:0] eventState;

  int compared   = 0;
  int mismatched = 0;

  logic [NE-1:0] mEv, mIrqEn, mNmiEn;
  logic          mIrq, mNmi, mRValid;
  logic [31:0]   mRData;

  always #5 clk = ~clk;

  event_irq_ctrl dut (
    .clk(clk), .rst(rst), .eventPulse(eventPulse), .parAddr(parAddr),
    .parWrEn(parWrEn), .parWData(parWData), .parWStrb(parWStrb),
    .parRdEn(parRdEn), .parRData(parRData), .parRValid(parRValid),
    .irq(irq), .nmi(nmi), .eventState(eventState)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isIrqReg(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h304) || (a == 12'h308);
  endfunction

  function automatic bit isNmiReg(input logic [11:0] a);
    return (a == 12'h320) || (a == 12'h324) || (a == 12'h328);
  endfunction

  function automatic int eventIndex(input logic [11:0] a);
    int off;
    off = int'(a) - 256;
    if (off >= 0 && off < 4 * NE && (off % 4) == 0) return off / 4;
    return -1;
  endfunction

  function automatic logic [31:0] mRead(input logic [11:0] a);
    int k;
    k = eventIndex(a);
    if (k >= 0) return {31'd0, mEv[k]};
    if (isIrqReg(a)) return {24'd0, mIrqEn};
`ifdef EVENT_IRQ_CTRL_NMI_EN
    if (isNmiReg(a)) return {24'd0, mNmiEn};
`endif
    return 32'd0;
  endfunction

  // Apply one enable-register write to a mask, bit by bit following its byte lane.
  function automatic logic [NE-1:0] enWrite(input logic [NE-1:0] cur, input int kind,
                                            input logic [31:0] d, input logic [3:0] s);
    logic [NE-1:0] r;
    r = cur;
    for (int i = 0; i < NE; i++) begin
      if (s[i / 8]) begin
        if (kind == 0) r[i] = d[i];
        else if (kind == 1 && d[i]) r[i] = 1'b1;
        else if (kind == 2 && d[i]) r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // One clock cycle: drive, advance model, clock, compare every output.
  task automatic step(input logic rd, input logic wr, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [NE-1:0] p, input logic r);
    int k;
    rst = r; parRdEn = rd; parWrEn = wr; parAddr = a; parWData = d; parWStrb = s;
    eventPulse = p;
    if (r) begin
      mEv = '0; mIrqEn = '0; mNmiEn = '0; mIrq = 1'b0; mNmi = 1'b0;
      mRValid = 1'b0; mRData = 32'd0;
    end else begin
      mRValid = rd;
      mRData  = rd ? mRead(a) : 32'd0;
      if (wr) begin
        k = eventIndex(a);
        if (k >= 0 && s[0]) mEv[k] = d[0];
        if (a == 12'h300) mIrqEn = enWrite(mIrqEn, 0, d, s);
        if (a == 12'h304) mIrqEn = enWrite(mIrqEn, 1, d, s);
        if (a == 12'h308) mIrqEn = enWrite(mIrqEn, 2, d, s);
`ifdef EVENT_IRQ_CTRL_NMI_EN
        if (a == 12'h320) mNmiEn = enWrite(mNmiEn, 0, d, s);
        if (a == 12'h324) mNmiEn = enWrite(mNmiEn, 1, d, s);
        if (a == 12'h328) mNmiEn = enWrite(mNmiEn, 2, d, s);
`endif
      end
      mEv  = mEv | p;
      mIrq = (mEv & mIrqEn) != '0;
      mNmi = (mEv & mNmiEn) != '0;
    end
    @(posedge clk);
    #1;
    check("irq", {31'd0, irq}, {31'd0, mIrq});
    check("nmi", {31'd0, nmi}, {31'd0, mNmi});
    check("eventState", {24'd0, eventState}, {24'd0, mEv});
    check("parRValid", {31'd0, parRValid}, {31'd0, mRValid});
    check("parRData", parRData, mRData);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 12'h000, 32'd0, 4'h0, '0, 1'b0);
  endtask

  task automatic rdReg(input logic [11:0] a);
    step(1'b1, 1'b0, a, 32'd0, 4'h0, '0, 1'b0);
  endtask

  task automatic wrReg(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    step(1'b0, 1'b1, a, d, s, '0, 1'b0);
  endtask

  initial begin
    logic [11:0] addrList [14];
    logic [11:0] a;
    logic        rd, wr, r;
    addrList = '{12'h100, 12'h104, 12'h108, 12'h10C, 12'h110, 12'h11C, 12'h120,
                 12'h300, 12'h304, 12'h308, 12'h320, 12'h324, 12'h328, 12'h30C};

    // Reset and reset-state reads
    step(1'b0, 1'b0, 12'h000, 32'd0, 4'h0, '0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 32'd0, 4'h0, '0, 1'b1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rvalid", {31'd0, parRValid}, 32'd0);
    rdReg(12'h100);
    check("rd100_valid", {31'd0, parRValid}, 32'd1);
    check("rd100_data", parRData, 32'd0);
    rdReg(12'h300);
    check("rd300_data", parRData, 32'd0);
    idle();
    check("idle_rvalid", {31'd0, parRValid}, 32'd0);

    // Enable set, event pulse, irq latency
    wrReg(12'h304, 32'h05, 4'hF);
    step(1'b0, 1'b0, 12'h000, 32'd0, 4'h0, 8'h04, 1'b0);
    check("pulse2_irq", {31'd0, irq}, 32'd1);
    rdReg(12'h108);
    check("rd108", parRData, 32'd1);
    rdReg(12'h300);
    check("rd300_05", parRData, 32'h05);

    // Clearing write drops irq; enable clear
    wrReg(12'h108, 32'd0, 4'hF);
    check("clr_irq", {31'd0, irq}, 32'd0);
    wrReg(12'h308, 32'h04, 4'hF);
    rdReg(12'h300);
    check("rd300_01", parRData, 32'h01);

    // Pulse beats same-cycle clearing write
    step(1'b0, 1'b1, 12'h10C, 32'd0, 4'hF, 8'h08, 1'b0);
    rdReg(12'h10C);
    check("set_wins", parRData, 32'd1);

    // NMI mask and event 7
    wrReg(12'h320, 32'h80, 4'hF);
    step(1'b0, 1'b0, 12'h000, 32'd0, 4'h0, 8'h80, 1'b0);
`ifdef EVENT_IRQ_CTRL_NMI_EN
    check("nmi_ev7", {31'd0, nmi}, 32'd1);
`else
    check("nmi_ev7", {31'd0, nmi}, 32'd0);
`endif
    check("irq_ev7", {31'd0, irq}, 32'd0);
    rdReg(12'h320);
`ifdef EVENT_IRQ_CTRL_NMI_EN
    check("rd320", parRData, 32'h80);
`else
    check("rd320", parRData, 32'h00);
`endif

    // Reset while irq high and a read is issued
    step(1'b0, 1'b0, 12'h000, 32'd0, 4'h0, 8'h01, 1'b0);
    check("irq_before_rst", {31'd0, irq}, 32'd1);
    step(1'b1, 1'b0, 12'h300, 32'd0, 4'h0, '0, 1'b0);
    step(1'b0, 1'b0, 12'h000, 32'd0, 4'h0, '0, 1'b1);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_rvalid", {31'd0, parRValid}, 32'd0);
    for (int i = 0; i < NE; i++) begin
      rdReg(12'h100 + 12'(4 * i));
      check("postrst_ev", parRData, 32'd0);
    end
    rdReg(12'h300);
    check("postrst_irqen", parRData, 32'd0);

    // Byte lanes: lane 1 carries no enable bits here
    wrReg(12'h300, 32'hFF, 4'h2);
    rdReg(12'h300);
    check("lane1_only", parRData, 32'd0);
    wrReg(12'h300, 32'hFF, 4'h1);
    rdReg(12'h304);
    check("lane0_load", parRData, 32'hFF);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      a  = addrList[$urandom_range(0, 13)];
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 63) == 0);
      step(rd, wr, a, $urandom, 4'($urandom), NE'($urandom & $urandom & $urandom), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/event_irq_ctrl.md
Name: event_irq_ctrl

Overview:
- Downstream stage of the event generator unit core. Latches the one-cycle event pulses from the core into PAR-accessible EVENTS registers.
- Holds the IRQ enable mask with write/set/clear registers, and optionally the NMI mask.
- Drives registered irq and nmi lines to the CPU interrupt controller.
- Sits between the event generator core and the PAR slave decoder.

Parameters:
- NUM_EVENTS, 8, number of event sources (1..32)
- PAR_AW, 12, PAR address width
- PAR_DW, 32, PAR data width
- PAR_WW, 4, PAR write-strobe width (byte lanes)
- EVENT_BASE, 'h100, address of EVENTS[0]; EVENTS[i] is at EVENT_BASE + 4*i
- IRQ_ENABLE_ADDR, 'h300, IRQ enable register (plain write)
- IRQ_SET_ADDR, 'h304, IRQ enable set register
- IRQ_CLR_ADDR, 'h308, IRQ enable clear register
- NMI_ENABLE_ADDR, 'h320, NMI enable register
- NMI_SET_ADDR, 'h324, NMI enable set register
- NMI_CLR_ADDR, 'h328, NMI enable clear register

Ports:
- clk  in  1  block clock
- rst  in  1  synchronous reset, active-high
- eventPulse  in  NUM_EVENTS  one-cycle event pulses from the core
- parAddr  in  PAR_AW  PAR address (byte address, word aligned)
- parWrEn  in  1  PAR write strobe, one cycle per access
- parWData  in  PAR_DW  PAR write data
- parWStrb  in  PAR_WW  byte-lane enables
- parRdEn  in  1  PAR read strobe
- parRData  out  PAR_DW  read data, valid while parRValid=1
- parRValid  out  1  read response, 1 cycle after parRdEn
- irq  out  1  interrupt request, level
- nmi  out  1  non-maskable interrupt request, level
- eventState  out  NUM_EVENTS  current EVENTS bits, for debug/PPI

Behaviour:
- Reset values (rst=1 at a clk edge): all event bits 0, irqEn=0, nmiEn=0, irq=0, nmi=0, parRValid=0, parRData=0.
- EVENTS[i] bit0 is sticky and set by eventPulse[i].
- PAR write to EVENTS[i] with parWStrb[0]=1: wdata[0]=0 clears the bit; wdata[0]=1 sets it (software trigger). Bits 31:1 read 0.
- Simultaneous eventPulse[i] and a clearing write in the same cycle: the set wins and the bit ends at 1.
- Enable-register writes apply per byte lane; only bits [NUM_EVENTS-1:0] exist.
  - IRQ_ENABLE_ADDR loads the register.
  - IRQ_SET_ADDR ORs the write data into it.
  - IRQ_CLR_ADDR clears every bit written as 1.
- Reads of IRQ_ENABLE, IRQ_SET and IRQ_CLR all return irqEn zero-extended. The NMI registers behave identically on nmiEn.
- Writes to unmapped addresses are ignored; reads of unmapped addresses return 0 with parRValid=1.
- Read latency: exactly 1 cycle. parRData is sampled from the register state before any same-cycle write takes effect (read-before-write).
- parRData returns to 0 when parRValid=0.
- parRdEn and parWrEn in the same cycle: both are performed.
- irq is registered: irq <= |(events_next & irqEn_next).
  - An event pulse in cycle N gives irq=1 in cycle N+1.
  - A clear write in cycle N gives irq=0 in cycle N+1 if no other enabled event is set.
- nmi is computed the same way from nmiEn. irq and nmi are independent: an event enabled in both masks drives both lines.
- eventState is the registered event bits, with the same timing as irq.
- Reset asserted mid-operation (pending read or irq high): next cycle all state returns to reset values and a pending parRValid is dropped.

Optional Feature:
- Macro: EVENT_IRQ_CTRL_NMI_EN.
- Defined: nmiEn and the three NMI registers are implemented as described above.
- Undefined:
  - No nmiEn flops; nmi is tied to 0.
  - NMI_* addresses are treated as unmapped: read 0, writes ignored.

Test Plan:
- Reset release, then read 'h100 and 'h300 -> parRValid=1 one cycle after each parRdEn, parRData=0; irq=0, nmi=0.
- Write 'h304 with 'h05; pulse eventPulse[2] at cycle N -> read 'h100+8 = 1; irq=1 at N+1; read 'h300 = 'h05.
- Hold irq high, write 0 to 'h108 -> irq=0 next cycle. Write 'h308 with 'h04 -> read 'h300 = 'h01.
- Apply eventPulse[3] and write 0 to 'h10C in the same cycle -> EVENTS[3] reads 1.
- With the macro defined, write 'h320 with 'h80 and pulse event 7 -> nmi=1 and irq=0 (irqEn bit7=0). Without the macro -> nmi stays 0 and a read of 'h320 returns 0.
- Assert rst while irq=1 and a read is pending -> next cycle irq=0, parRValid=0, and all registers read 0.
